mem_addr_stepper: RTL and testbench

Parametrised button-driven address generator for the Basys-3 memory exercises; successor to the single-step inc/dec address counter. It debounces two pushbuttons, steps once per press, and auto-repeats while a button is held. It supports configurable depth with wrap or saturate at the ends, plus a direct address load. One instance drives each RAM port address (write and read) in the top level; `delta` feeds the RAM enables and the seven-segment reload.

---
 rtl/mem_addr_stepper.sv | 205 ++++++++++++++++++++
 tb/tb_mem_addr_stepper.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_addr_stepper.sv
// mem_addr_stepper
//   Button-driven address generator. Each pushbutton is synchronised and
//   debounced. A debounced press steps the address once, and holding the
//   button auto-repeats it. The address either wraps or saturates at the
//   ends of the valid range. A direct load overrides stepping.
//
// Ports
//   clk         system clock
//   reset       asynchronous active-high reset
//   inc_button  raw increment button (asynchronous)
//   dec_button  raw decrement button (asynchronous)
//   load        single-cycle load strobe
//   load_addr   value to load (clamped to DEPTH-1)
//   addr        current address (registered)
//   delta       one-cycle pulse when addr takes a new or reloaded value
//   at_min      addr == 0
//   at_max      addr == DEPTH-1
module mem_addr_stepper #(
    parameter int unsigned ADDR_W       = 10,
    parameter int unsigned DEPTH        = 1024,
    parameter int unsigned WRAP         = 1,
    parameter int unsigned DEBOUNCE_CYC = 1_000_000,
    parameter int unsigned REPEAT_DELAY = 50_000_000,
    parameter int unsigned REPEAT_RATE  = 10_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inc_button,
    input  logic              dec_button,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    output logic [ADDR_W-1:0] addr,
    output logic              delta,
    output logic              at_min,
    output logic              at_max
);

    localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYC + 1);
    localparam int unsigned TMR_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [TMR_W-1:0]  TMR_DELAY = TMR_W'(REPEAT_DELAY);
    localparam logic [TMR_W-1:0]  TMR_RATE  = TMR_W'(REPEAT_RATE);
    localparam logic [TMR_W-1:0]  TMR_ONE   = TMR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DELAY,
        ST_REPEAT,
        ST_BLOCKED
    } state_t;

    // Bit 0 = increment button, bit 1 = decrement button.
    logic [1:0]            sync1_q, sync1_d;
    logic [1:0]            sync2_q, sync2_d;
    logic [1:0]            lvl_q, lvl_d;
    logic [1:0]            lvl_prev_q, lvl_prev_d;
    logic [1:0][DB_W-1:0]  cnt_q, cnt_d;

    state_t                state_q, state_d;
    logic [TMR_W-1:0]      timer_q, timer_d;
    logic                  dir_q, dir_d;        // 0 = increment, 1 = decrement
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic                  delta_q, delta_d;
    logic                  first_q, first_d;    // pending post-reset notification

    logic [1:0]            rise;
    logic                  step_req;
    logic                  active_lvl;
    logic                  timer_done;
    logic                  step;
    logic                  step_dir;

    // Synchronisers and debouncers.
    always_comb begin
        sync1_d    = {dec_button, inc_button};
        sync2_d    = sync1_q;
        lvl_prev_d = lvl_q;
        for (int unsigned i = 0; i < 2; i++) begin
            lvl_d[i] = lvl_q[i];
            cnt_d[i] = '0;
            if (sync2_q[i] != lvl_q[i]) begin
                if (cnt_q[i] == DB_LAST) begin
                    lvl_d[i] = ~lvl_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    assign rise       = lvl_q & ~lvl_prev_q;
    assign step_req   = (rise[0] & ~lvl_q[1]) | (rise[1] & ~lvl_q[0]);
    assign active_lvl = dir_q ? lvl_q[1] : lvl_q[0];
    // Timer is loaded with N on the step edge, so a value of one means
    // the next edge lands exactly N cycles after that step.
    assign timer_done = (timer_q == TMR_ONE);

    // Repeat state machine.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        dir_d    = dir_q;
        step     = 1'b0;
        step_dir = dir_q;
        if (&lvl_q) begin
            state_d = ST_BLOCKED;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (step_req) begin
                        step     = 1'b1;
                        step_dir = rise[1];
                        dir_d    = rise[1];
                        timer_d  = TMR_DELAY;
                        state_d  = ST_DELAY;
                    end
                end
                ST_DELAY, ST_REPEAT: begin
                    if (!active_lvl) begin
                        state_d = ST_IDLE;
                    end else if (timer_done) begin
                        step    = 1'b1;
                        timer_d = TMR_RATE;
                        state_d = ST_REPEAT;
                    end else begin
                        timer_d = timer_q - TMR_ONE;
                    end
                end
                ST_BLOCKED: begin
                    if (lvl_q == 2'b00) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Address update: load beats step; a saturated step leaves delta low.
    always_comb begin
        addr_d  = addr_q;
        delta_d = first_q;
        first_d = 1'b0;
        if (load) begin
            addr_d  = ({1'b0, load_addr} < DEPTH_EXT) ? load_addr : ADDR_LAST;
            delta_d = 1'b1;
        end else if (step) begin
            if (!step_dir) begin
                if (addr_q != ADDR_LAST) begin
                    addr_d  = addr_q + ADDR_W'(1);
                    delta_d = 1'b1;
                end else if (WRAP != 0) begin
                    addr_d  = '0;
                    delta_d = 1'b1;
                end
            end else begin
                if (addr_q != '0) begin
                    addr_d  = addr_q - ADDR_W'(1);
                    delta_d = 1'b1;
                end else if (WRAP != 0) begin
                    addr_d  = ADDR_LAST;
                    delta_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            lvl_q      <= '0;
            lvl_prev_q <= '0;
            cnt_q      <= '0;
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            dir_q      <= 1'b0;
            addr_q     <= '0;
            delta_q    <= 1'b0;
            first_q    <= 1'b1;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            lvl_q      <= lvl_d;
            lvl_prev_q <= lvl_prev_d;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            timer_q    <= timer_d;
            dir_q      <= dir_d;
            addr_q     <= addr_d;
            delta_q    <= delta_d;
            first_q    <= first_d;
        end
    end

    assign addr   = addr_q;
    assign delta  = delta_q;
    assign at_min = (addr_q == '0);
    assign at_max = (addr_q == ADDR_LAST);

endmodule

// File: tb/tb_mem_addr_stepper.sv
// Testbench for mem_addr_stepper. Two instances share all inputs: one
// wraps at the ends and one saturates. A behavioural model pushes each
// expected address notification into a per-instance queue, and a monitor
// pops and compares it against the outputs after every clock edge.
module tb_mem_addr_stepper;

    localparam int unsigned AW  = 4;
    localparam int          DEP = 10;
    localparam int          DB  = 4;
    localparam int          RD  = 20;
    localparam int          RR  = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          inc_b, dec_b, load;
    logic [AW-1:0] load_addr;
    logic [AW-1:0] addr_w, addr_s;
    logic          delta_w, delta_s, min_w, min_s, max_w, max_s;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_addr_stepper #(
        .ADDR_W(AW), .DEPTH(DEP), .WRAP(1),
        .DEBOUNCE_CYC(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
    ) u_wrap (
        .clk(clk), .reset(reset), .inc_button(inc_b), .dec_button(dec_b),
        .load(load), .load_addr(load_addr), .addr(addr_w), .delta(delta_w),
        .at_min(min_w), .at_max(max_w)
    );

    mem_addr_stepper #(
        .ADDR_W(AW), .DEPTH(DEP), .WRAP(0),
        .DEBOUNCE_CYC(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
    ) u_sat (
        .clk(clk), .reset(reset), .inc_button(inc_b), .dec_button(dec_b),
        .load(load), .load_addr(load_addr), .addr(addr_s), .delta(delta_s),
        .at_min(min_s), .at_max(max_s)
    );

    // ---------------- reference model ----------------
    int       q_w[$];
    int       q_s[$];
    int       m_addr[2];
    bit       m_first;
    bit [1:0] h1, h2;          // raw samples from the last two edges
    bit [1:0] deb, prev_deb;   // accepted button levels
    int       run[2];          // consecutive disagreeing cycles
    int       mode;            // 0 idle, 1 holding a button, 2 both held
    int       dir;             // 0 increment, 1 decrement
    int       since;           // cycles since the first step of a hold

    initial begin
        m_addr[0] = 0; m_addr[1] = 0; m_first = 1'b1;
        h1 = '0; h2 = '0; deb = '0; prev_deb = '0;
        run[0] = 0; run[1] = 0; mode = 0; dir = 0; since = 0;
    end

    always @(posedge clk) begin : model
        bit [1:0] cur, rise, synced;
        bit       step;
        int       na;
        bit       d;
        if (reset) begin
            m_addr[0] = 0; m_addr[1] = 0; m_first = 1'b1;
            h1 = '0; h2 = '0; deb = '0; prev_deb = '0;
            run[0] = 0; run[1] = 0; mode = 0; since = 0;
            q_w.delete(); q_s.delete();
        end else begin
            synced = h2;
            h2 = h1;
            h1 = {dec_b, inc_b};
            cur = deb;
            rise = cur & ~prev_deb;
            prev_deb = cur;
            for (int b = 0; b < 2; b++) begin
                if (synced[b] != deb[b]) begin
                    run[b]++;
                    if (run[b] == DB) begin
                        deb[b] = ~deb[b];
                        run[b] = 0;
                    end
                end else begin
                    run[b] = 0;
                end
            end
            step = 1'b0;
            if (cur == 2'b11) begin
                mode = 2;
            end else if (mode == 0) begin
                if (rise[0] && !cur[1]) begin
                    step = 1'b1; dir = 0; mode = 1; since = 0;
                end else if (rise[1] && !cur[0]) begin
                    step = 1'b1; dir = 1; mode = 1; since = 0;
                end
            end else if (mode == 1) begin
                if (!cur[dir]) begin
                    mode = 0;
                end else begin
                    since++;
                    if (since == RD || (since > RD && (since - RD) % RR == 0))
                        step = 1'b1;
                end
            end else begin
                if (cur == 2'b00) mode = 0;
            end
            for (int i = 0; i < 2; i++) begin
                na = m_addr[i];
                d  = m_first;
                if (load) begin
                    na = (int'(load_addr) < DEP) ? int'(load_addr) : DEP - 1;
                    d  = 1'b1;
                end else if (step) begin
                    if (dir == 0) begin
                        if (na == DEP - 1) begin
                            if (i == 0) begin na = 0; d = 1'b1; end
                        end else begin
                            na = na + 1; d = 1'b1;
                        end
                    end else begin
                        if (na == 0) begin
                            if (i == 0) begin na = DEP - 1; d = 1'b1; end
                        end else begin
                            na = na - 1; d = 1'b1;
                        end
                    end
                end
                m_addr[i] = na;
                if (d) begin
                    if (i == 0) q_w.push_back(na);
                    else        q_s.push_back(na);
                end
            end
            m_first = 1'b0;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    task automatic check_inst(input int i, input logic [AW-1:0] a, input logic d,
                              input logic mn, input logic mx);
        int qsz;
        int e;
        bit emn, emx;
        qsz = (i == 0) ? q_w.size() : q_s.size();
        total++;
        if (qsz > 0) begin
            if (i == 0) e = q_w.pop_front();
            else        e = q_s.pop_front();
            if (d !== 1'b1 || int'(a) != e) begin
                bad++;
                $display("FAIL step[%0d] t=%0t delta=%0b addr=%0d required delta=1 addr=%0d",
                         i, $time, d, a, e);
            end
        end else if (d !== 1'b0) begin
            bad++;
            $display("FAIL spurious_delta[%0d] t=%0t delta=%0b addr=%0d required delta=0",
                     i, $time, d, a);
        end
        emn = (m_addr[i] == 0);
        emx = (m_addr[i] == DEP - 1);
        total++;
        if (mn !== emn || mx !== emx) begin
            bad++;
            $display("FAIL flags[%0d] t=%0t at_min=%0b at_max=%0b required %0b %0b",
                     i, $time, mn, mx, emn, emx);
        end
    endtask

    always @(posedge clk) begin
        #1;
        check_inst(0, addr_w, delta_w, min_w, max_w);
        check_inst(1, addr_s, delta_s, min_s, max_s);
    end

    // ---------------- stimulus ----------------
    task automatic check_eq(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, req);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input int v);
        load = 1'b1;
        load_addr = AW'(v);
        @(negedge clk);
        load = 1'b0;
    endtask

    initial begin
        reset = 1'b1; inc_b = 1'b0; dec_b = 1'b0; load = 1'b0; load_addr = '0;
        cycles(3);
        check_eq("reset_addr",   int'(addr_w), 0);
        check_eq("reset_delta",  int'(delta_w), 0);
        check_eq("reset_at_min", int'(min_w), 1);
        check_eq("reset_at_max", int'(max_w), 0);
        reset = 1'b0;
        cycles(5);

        // Bouncing press, then a clean hold shorter than the repeat delay.
        inc_b = 1; cycles(2); inc_b = 0; cycles(1);
        inc_b = 1; cycles(2); inc_b = 0; cycles(1);
        inc_b = 1; cycles(1); inc_b = 0; cycles(1);
        inc_b = 1; cycles(10); inc_b = 0; cycles(12);
        check_eq("single_step_addr", int'(addr_w), 1);

        // Auto-repeat downward through zero.
        do_load(3); cycles(2);
        dec_b = 1; cycles(40); dec_b = 0; cycles(12);

        // Hold increment from 8: wrap instance wraps, saturate instance sticks.
        do_load(8); cycles(2);
        inc_b = 1; cycles(40);
        check_eq("saturate_addr", int'(addr_s), 9);
        check_eq("saturate_at_max", int'(max_s), 1);
        inc_b = 0; cycles(12);

        // Both buttons held blocks stepping until both are released.
        inc_b = 1; cycles(30);
        dec_b = 1; cycles(20);
        dec_b = 0; cycles(20);
        inc_b = 0; cycles(12);
        inc_b = 1; cycles(10);
        inc_b = 0; cycles(12);

        // Out-of-range load clamps; loads coincide with repeat steps.
        do_load(12);
        check_eq("load_clamp", int'(addr_w), 9);
        cycles(2);
        inc_b = 1; cycles(30);
        load = 1'b1; load_addr = 4'd2; cycles(10); load = 1'b0;
        check_eq("load_wins", int'(addr_w), 2);
        cycles(10);
        inc_b = 0; cycles(12);

        // Reset mid-hold with addr at 7; the held button is debounced again.
        do_load(6);
        inc_b = 1; cycles(8);
        check_eq("pre_reset_addr", int'(addr_w), 7);
        reset = 1'b1;
        #1;
        check_eq("async_reset_addr", int'(addr_w), 0);
        check_eq("async_reset_at_min", int'(min_w), 1);
        cycles(2);
        reset = 1'b0;
        cycles(30);
        inc_b = 0; cycles(12);

        // Randomised button activity with sporadic loads.
        for (int it = 0; it < 200; it++) begin
            int r, dur;
            r = int'($urandom_range(0, 9));
            inc_b = (r < 4) || (r == 8);
            dec_b = (r >= 4 && r < 7) || (r == 8);
            dur = int'($urandom_range(1, 30));
            for (int c = 0; c < dur; c++) begin
                load = ($urandom_range(0, 19) == 0);
                load_addr = AW'($urandom_range(0, 15));
                @(negedge clk);
            end
            load = 1'b0;
        end
        inc_b = 0; dec_b = 0;
        cycles(15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
